pulse_sync_f2s_mc: RTL

//  Multi-channel fast-to-slow single-pulse synchronizer. Each channel uses a 4-phase req/ack handshake.

---
 rtl/pulse_sync_f2s_mc.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/pulse_sync_f2s_mc.sv
// pulse_sync_f2s_mc: multi-channel fast(clka) -> slow(clkb) single-pulse synchronizer, 4-phase req/ack per channel.
// Latency: dout pulses on the (SYNC_STAGES+1)th clkb edge after req rises; a channel stays busy ~2*(SYNC_STAGES+1) clkb + 2*SYNC_STAGES clka.
// Backpressure: none on din; a pulse arriving while its channel is busy is dropped, flagged on sync_fail and counted in drop_cnt.
//
// Ports:
//   clka, clkb   source (fast) and destination (slow) clocks
//   rst          asynchronous active-high reset, clears both domains
//   din          clka single-cycle event pulses, one bit per channel
//   clr_cnt      clka synchronous clear of every drop counter (wins over a same-cycle increment)
//   busy         clka, channel handshake in flight (or a pulse pending)
//   sync_fail    clka, 1-cycle pulse the cycle after din[i] was dropped
//   drop_cnt     clka, saturating per-channel drop counts, channel i at [i*CNT_W +: CNT_W]
//   dout         clkb, registered 1-cycle output pulse per channel
//
// Build option F2S_PEND_EN: adds a 1-deep pending flag per channel so one pulse arriving during a
// handshake is held and launched once the channel returns to idle; only pulses beyond that are dropped.
module pulse_sync_f2s_mc #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                 clka,
  input  logic                 clkb,
  input  logic                 rst,
  input  logic [NCH-1:0]       din,
  input  logic                 clr_cnt,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       sync_fail,
  output logic [NCH*CNT_W-1:0] drop_cnt,
  output logic [NCH-1:0]       dout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // ---------------- clka domain ----------------
  state_t           state_q    [NCH];
  state_t           state_d    [NCH];
  logic [NCH-1:0]   req_q;
  logic [NCH-1:0]   req_d;
  logic [NCH-1:0]   ack_sync_q [SYNC_STAGES];
  logic [NCH-1:0]   ack_sync_d [SYNC_STAGES];
  logic [NCH-1:0]   ack_s;
  logic [NCH-1:0]   busy_q;
  logic [NCH-1:0]   busy_d;
  logic [NCH-1:0]   sync_fail_q;
  logic [NCH-1:0]   sync_fail_d;
  logic [CNT_W-1:0] cnt_q      [NCH];
  logic [CNT_W-1:0] cnt_d      [NCH];
  logic [NCH-1:0]   launch;
  logic [NCH-1:0]   drop;
`ifdef F2S_PEND_EN
  logic [NCH-1:0]   pend_q;
  logic [NCH-1:0]   pend_d;
`endif

  // ---------------- clkb domain ----------------
  logic [NCH-1:0]   req_sync_q [SYNC_STAGES];
  logic [NCH-1:0]   req_sync_d [SYNC_STAGES];
  logic [NCH-1:0]   req_s;
  logic [NCH-1:0]   req_prev_q;
  logic [NCH-1:0]   req_prev_d;
  logic [NCH-1:0]   dout_q;
  logic [NCH-1:0]   dout_d;

  assign ack_s = ack_sync_q[SYNC_STAGES-1];
  assign req_s = req_sync_q[SYNC_STAGES-1];

  // The clkb side acknowledges with its synchronized copy of req; bring it back into clka.
  always_comb begin
    ack_sync_d[0] = req_s;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      ack_sync_d[k] = ack_sync_q[k-1];
    end
  end

  // Per-channel handshake FSM, drop detection and drop counters.
  always_comb begin
    req_d       = req_q;
    launch      = '0;
    drop        = '0;
    busy_d      = '0;
    sync_fail_d = '0;
`ifdef F2S_PEND_EN
    pend_d      = pend_q;
`endif
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];

`ifdef F2S_PEND_EN
      // A held pulse launches as soon as the channel is idle. A din that arrives while
      // the flag is already set (including the launching cycle) has nowhere to go.
      launch[i] = (state_q[i] == ST_IDLE) & (din[i] | pend_q[i]);
      drop[i]   = din[i] & pend_q[i];
      if (state_q[i] == ST_IDLE) begin
        pend_d[i] = 1'b0;
      end else if (din[i] && !pend_q[i]) begin
        pend_d[i] = 1'b1;
      end
`else
      // Decision is on the current state, so a din in the DRAIN cycle where ack_s
      // falls is still a drop.
      launch[i] = (state_q[i] == ST_IDLE) & din[i];
      drop[i]   = (state_q[i] != ST_IDLE) & din[i];
`endif

      case (state_q[i])
        ST_IDLE: begin
          if (launch[i]) begin
            req_d[i]   = 1'b1;
            state_d[i] = ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack_s[i]) begin
            req_d[i]   = 1'b0;
            state_d[i] = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!ack_s[i]) begin
            state_d[i] = ST_IDLE;
          end
        end
        default: begin
          req_d[i]   = 1'b0;
          state_d[i] = ST_IDLE;
        end
      endcase

      sync_fail_d[i] = drop[i];

      if (clr_cnt) begin
        cnt_d[i] = '0;
      end else if (drop[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end

`ifdef F2S_PEND_EN
      busy_d[i] = (state_d[i] != ST_IDLE) | pend_d[i];
`else
      busy_d[i] = (state_d[i] != ST_IDLE);
`endif
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      for (int k = 0; k < SYNC_STAGES; k++) begin
        ack_sync_q[k] <= '0;
      end
      req_q       <= '0;
      busy_q      <= '0;
      sync_fail_q <= '0;
`ifdef F2S_PEND_EN
      pend_q      <= '0;
`endif
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      for (int k = 0; k < SYNC_STAGES; k++) begin
        ack_sync_q[k] <= ack_sync_d[k];
      end
      req_q       <= req_d;
      busy_q      <= busy_d;
      sync_fail_q <= sync_fail_d;
`ifdef F2S_PEND_EN
      pend_q      <= pend_d;
`endif
    end
  end

  // clkb: synchronize req, then edge-detect its rising edge into a registered pulse.
  always_comb begin
    req_sync_d[0] = req_q;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      req_sync_d[k] = req_sync_q[k-1];
    end
    req_prev_d = req_s;
    dout_d     = req_s & ~req_prev_q;
  end

  always_ff @(posedge clkb or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        req_sync_q[k] <= '0;
      end
      req_prev_q <= '0;
      dout_q     <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        req_sync_q[k] <= req_sync_d[k];
      end
      req_prev_q <= req_prev_d;
      dout_q     <= dout_d;
    end
  end

  assign busy      = busy_q;
  assign sync_fail = sync_fail_q;
  assign dout      = dout_q;

  for (genvar g = 0; g < NCH; g++) begin : g_cnt
    assign drop_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule
